// File: rtl/reg_file_2r1w.sv
// Two-read, one-write register file with a hardwired zero register at the top index.
// Reads are combinational and forward a same-cycle write so the operand muxes see fresh data.
module reg_file_2r1w #(
    parameter int DATA_WIDTH = 64,
    parameter int REG_COUNT  = 32,
    parameter int ADDR_WIDTH = $clog2(REG_COUNT)
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  write_en_i,
    input  logic [ADDR_WIDTH-1:0] write_addr_i,
    input  logic [DATA_WIDTH-1:0] write_data_i,
    input  logic [ADDR_WIDTH-1:0] read_addr_a_i,
    input  logic [ADDR_WIDTH-1:0] read_addr_b_i,
    output logic [DATA_WIDTH-1:0] read_data_a_o,
    output logic [DATA_WIDTH-1:0] read_data_b_o
);

    localparam logic [ADDR_WIDTH-1:0] XZR_IDX = ADDR_WIDTH'(REG_COUNT - 1);

    logic [DATA_WIDTH-1:0] regs [REG_COUNT-1];
    logic                  write_ok;
    logic                  hit_a;
    logic                  hit_b;

    // XZR and any unimplemented index above it all compare >= XZR_IDX.
    assign write_ok = write_en_i && (write_addr_i < XZR_IDX);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < REG_COUNT - 1; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < REG_COUNT - 1; i++) begin
                if (write_ok && (write_addr_i == ADDR_WIDTH'(i))) begin
                    regs[i] <= write_data_i;
                end
            end
        end
    end

    assign hit_a = !reset_i && write_ok && (write_addr_i == read_addr_a_i);
    assign hit_b = !reset_i && write_ok && (write_addr_i == read_addr_b_i);

    always_comb begin
        read_data_a_o = '0;
        if (!reset_i) begin
            if (hit_a) begin
                read_data_a_o = write_data_i;
            end else begin
                for (int i = 0; i < REG_COUNT - 1; i++) begin
                    if (read_addr_a_i == ADDR_WIDTH'(i)) begin
                        read_data_a_o = regs[i];
                    end
                end
            end
        end
    end

    always_comb begin
        read_data_b_o = '0;
        if (!reset_i) begin
            if (hit_b) begin
                read_data_b_o = write_data_i;
            end else begin
                for (int i = 0; i < REG_COUNT - 1; i++) begin
                    if (read_addr_b_i == ADDR_WIDTH'(i)) begin
                        read_data_b_o = regs[i];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Bench for reg_file_2r1w: directed scenarios followed by randomized traffic
// checked against an array model of the architectural registers.
module tb_reg_file_2r1w;

    localparam int DW = 64;
    localparam int RC = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset_i = 1'b0;
    logic          write_en_i = 1'b0;
    logic [AW-1:0] write_addr_i = '0;
    logic [DW-1:0] write_data_i = '0;
    logic [AW-1:0] read_addr_a_i = '0;
    logic [AW-1:0] read_addr_b_i = '0;
    logic [DW-1:0] read_data_a_o;
    logic [DW-1:0] read_data_b_o;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] mdl [RC];

    reg_file_2r1w #(
        .DATA_WIDTH(DW),
        .REG_COUNT (RC)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .write_en_i   (write_en_i),
        .write_addr_i (write_addr_i),
        .write_data_i (write_data_i),
        .read_addr_a_i(read_addr_a_i),
        .read_addr_b_i(read_addr_b_i),
        .read_data_a_o(read_data_a_o),
        .read_data_b_o(read_data_b_o)
    );

    always #5 clk = ~clk;

    // Architectural view: reset reads zero, XZR reads zero, a pending write wins, else the stored value.
    function automatic logic [DW-1:0] expect_rd(input logic [AW-1:0] a);
        if (reset_i) return '0;
        if (int'(a) == RC - 1) return '0;
        if (write_en_i && write_addr_i == a) return write_data_i;
        return mdl[a];
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_ports(input string tag);
        check({tag, "_a"}, read_data_a_o, expect_rd(read_addr_a_i));
        check({tag, "_b"}, read_data_b_o, expect_rd(read_addr_b_i));
    endtask

    task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic [AW-1:0] ra, input logic [AW-1:0] rb);
        write_en_i    = we;
        write_addr_i  = wa;
        write_data_i  = wd;
        read_addr_a_i = ra;
        read_addr_b_i = rb;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset_i && write_en_i && int'(write_addr_i) != RC - 1) mdl[write_addr_i] = write_data_i;
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < RC; i++) mdl[i] = '0;
    endtask

    initial begin
        clear_model();

        // Reset from time zero, with a write held across an edge.
        reset_i = 1'b1;
        drive(1'b1, 5'd2, 64'h77, 5'd2, 5'd31);
        check("rst_bypass_a", read_data_a_o, 64'h0);
        check("rst_xzr_b", read_data_b_o, 64'h0);
        tick();
        check("rst_hold_x2", read_data_a_o, 64'h0);
        reset_i = 1'b0;
        drive(1'b0, 5'd0, 64'h0, 5'd2, 5'd5);
        check("post_rst_x2", read_data_a_o, 64'h0);
        check("post_rst_x5", read_data_b_o, 64'h0);

        // Basic write/read.
        drive(1'b1, 5'd3, 64'h0123_4567_89AB_CDEF, 5'd3, 5'd4);
        tick();
        drive(1'b0, 5'd0, 64'h0, 5'd3, 5'd4);
        check("x3_read", read_data_a_o, 64'h0123_4567_89AB_CDEF);
        check("x4_read", read_data_b_o, 64'h0);

        // Zero register.
        drive(1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd31);
        check("xzr_pre_a", read_data_a_o, 64'h0);
        check("xzr_pre_b", read_data_b_o, 64'h0);
        tick();
        check("xzr_post_a", read_data_a_o, 64'h0);
        check("xzr_post_b", read_data_b_o, 64'h0);

        // Same-cycle bypass on both ports.
        drive(1'b1, 5'd7, 64'h11, 5'd7, 5'd7);
        tick();
        drive(1'b1, 5'd7, 64'h22, 5'd7, 5'd7);
        check("byp_pre_a", read_data_a_o, 64'h22);
        check("byp_pre_b", read_data_b_o, 64'h22);
        tick();
        drive(1'b0, 5'd0, 64'h0, 5'd7, 5'd7);
        check("byp_post_a", read_data_a_o, 64'h22);
        check("byp_post_b", read_data_b_o, 64'h22);

        // Write disabled.
        drive(1'b1, 5'd9, 64'hAA, 5'd9, 5'd9);
        tick();
        drive(1'b0, 5'd9, 64'h55, 5'd9, 5'd9);
        check("wdis_pre", read_data_a_o, 64'hAA);
        tick();
        check("wdis_post", read_data_b_o, 64'hAA);

        // Mid-cycle reset pulse clears stored data asynchronously.
        drive(1'b1, 5'd5, 64'hDEAD_BEEF, 5'd5, 5'd3);
        tick();
        drive(1'b0, 5'd0, 64'h0, 5'd5, 5'd3);
        check("x5_written", read_data_a_o, 64'hDEAD_BEEF);
        #1;
        reset_i = 1'b1;
        clear_model();
        #1;
        check("x5_in_rst", read_data_a_o, 64'h0);
        check("x3_in_rst", read_data_b_o, 64'h0);
        reset_i = 1'b0;
        #1;
        check("x5_after_rst", read_data_a_o, 64'h0);
        tick();
        check("x5_after_edge", read_data_a_o, 64'h0);
        check("x3_after_edge", read_data_b_o, 64'h0);

        // Randomized traffic with occasional asynchronous reset pulses.
        for (int n = 0; n < 400; n++) begin
            logic          we;
            logic [AW-1:0] wa, ra, rb;
            logic [DW-1:0] wd;
            we = ($urandom_range(0, 3) != 0);
            wa = AW'($urandom_range(0, RC - 1));
            wd = {$urandom, $urandom};
            ra = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, RC - 1));
            rb = ($urandom_range(0, 3) == 0) ? ra : AW'($urandom_range(0, RC - 1));
            drive(we, wa, wd, ra, rb);
            check_ports("rnd_pre");
            if ($urandom_range(0, 39) == 0) begin
                reset_i = 1'b1;
                clear_model();
                #1;
                check_ports("rnd_rst");
                reset_i = 1'b0;
            end
            tick();
            drive(1'b0, wa, wd, ra, rb);
            check_ports("rnd_post");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file_2r1w.md
REG_FILE_2R1W -- requirements
Module: reg_file_2r1w

Interface
REQ-001 Parameter DATA_WIDTH, default 64: width of each register and of each read/write data port.
REQ-002 Parameter REG_COUNT, default 32: number of architectural registers; index REG_COUNT-1 is the zero register (XZR).
REQ-003 Parameter ADDR_WIDTH, default $clog2(REG_COUNT): width of every register index port.
REQ-004 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-005 reset_i  input  1  reset, asynchronous and active-high.
REQ-006 write_en_i  input  1  write strobe for the write port.
REQ-007 write_addr_i  input  ADDR_WIDTH  destination register index.
REQ-008 write_data_i  input  DATA_WIDTH  data to write.
REQ-009 read_addr_a_i  input  ADDR_WIDTH  read port A register index.
REQ-010 read_addr_b_i  input  ADDR_WIDTH  read port B register index.
REQ-011 read_data_a_o  output  DATA_WIDTH  port A data; drives input 0 of the downstream ALU-operand 4x1 forwarding mux.
REQ-012 read_data_b_o  output  DATA_WIDTH  port B data; drives input 0 of the second forwarding mux.

Function
REQ-013 The block SHALL hold REG_COUNT-1 writable DATA_WIDTH-bit registers, indices 0..REG_COUNT-2.
REQ-014 On a rising clk_i edge with reset_i low, write_en_i high, and write_addr_i != REG_COUNT-1, the block SHALL load write_data_i into register write_addr_i.
REQ-015 A write SHALL be ignored when write_en_i is low or write_addr_i == REG_COUNT-1, leaving all stored state unchanged.
REQ-016 Reads SHALL be combinational, with zero cycle latency from address to data.
REQ-017 A read of index REG_COUNT-1 SHALL return all zeros regardless of write activity.
REQ-018 Same-cycle bypass: when write_en_i is high, write_addr_i equals a read address, and that address != REG_COUNT-1, the corresponding read port SHALL return write_data_i in the same cycle, before the edge.
REQ-019 When both read ports address the same register, both ports SHALL return identical data, including the bypass case.
REQ-020 Addresses >= REG_COUNT, which are reachable only when REG_COUNT is not a power of two, SHALL read as zero and SHALL be ignored as write targets.
REQ-021 Bypass SHALL be suppressed while reset_i is high, so both outputs read the reset contents.
REQ-022 The block SHALL contain no clock gating and no latches; storage SHALL use edge-triggered flops only.

Reset
REQ-023 Assertion of reset_i SHALL immediately clear every register to 0, without waiting for a clock edge.
REQ-024 While reset_i is high, read_data_a_o and read_data_b_o SHALL be 0 for every address.
REQ-025 A write coincident with reset_i high SHALL be discarded; reset takes priority.
REQ-026 After reset_i deasserts, the first rising edge SHALL accept writes normally.
REQ-027 Reset asserted mid-operation, between edges, SHALL clear state and outputs asynchronously; previously written data SHALL NOT reappear after deassertion.

Verification
REQ-028 Reset clear:
- Stimulus: write 0xDEAD_BEEF to X5, then pulse reset_i mid-cycle.
- Required response: reads of X5 give 0 immediately and after reset deasserts.
REQ-029 Basic write/read:
- Stimulus: write 0x0123_4567_89AB_CDEF to X3 at edge N; read_addr_a_i=3 after edge N.
- Required response: read_data_a_o=0x0123_4567_89AB_CDEF; read_data_b_o on X4 = 0.
REQ-030 XZR:
- Stimulus: write 0xFFFF_FFFF_FFFF_FFFF to X31; read X31 on both ports.
- Required response: both ports = 0, before and after the edge.
REQ-031 Bypass:
- Stimulus: X7 holds 0x11; drive write_en_i=1, write_addr_i=7, write_data_i=0x22; read_addr_a_i=read_addr_b_i=7.
- Required response: both ports show 0x22 before the edge; 0x22 persists after the edge.
REQ-032 Write disabled:
- Stimulus: write_en_i=0, write_addr_i=9, write_data_i=0x55, with X9 holding 0xAA.
- Required response: X9 reads 0xAA after the edge; no bypass is observed.
REQ-033 Write under reset:
- Stimulus: hold reset_i=1 across an edge with write_en_i=1, write_addr_i=2, write_data_i=0x77; then release reset.
- Required response: X2 reads 0.
